bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Time-multiplexed controller for 2-digit 7-segment displays.
- Accepts 7-bit binary values (0-99) from a host through a valid/ready write port and stores them per display pair.
- Converts each value to tens/ones BCD with a sequential subtract-10 engine, then scans all digits onto one shared segment bus with one-hot digit enables.
- Sits between the value producers (counters, timers) and the physical LED 7-segment pins.

Parameters:
- NUM_PAIRS, 2, number of 2-digit display pairs (1..8); digit count is 2*NUM_PAIRS.
- REFRESH_DIV, 50000, clocks each digit stays enabled (>=2).
- ACTIVE_LOW_SEG, 0, 1 inverts seg outputs for common-anode panels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- wr_en  in  1  write request
- wr_idx  in  max(1,$clog2(NUM_PAIRS))  target pair index
- wr_val  in  7  binary value to show
- wr_ready  out  1  converter idle; write accepted when wr_en && wr_ready
- blank_lz  in  1  blank tens digit when it is 0
- seg  out  7  segment pattern, bit order gfedcba
- dig_en  out  2*NUM_PAIRS  one-hot digit enable, active-high; bit 2k = ones of pair k, bit 2k+1 = tens of pair k
- busy  out  1  conversion in progress (equals ~wr_ready)

Behaviour:
- One clock domain. Reset is synchronous and active-low on rst_n, sampled on rising clk.
- Reset state:
  - all stored digits 0, ovf flags 0
  - FSM IDLE, wr_ready=1, busy=0
  - refresh counter 0, scan index 0
  - dig_en=0, seg=blank (0, or 7'h7F when ACTIVE_LOW_SEG=1)
- First cycle after reset release: dig_en=...0001.
- FSM states IDLE, CONVERT, STORE:
  - IDLE: on wr_en && wr_ready, latch wr_idx/wr_val into rem/idx and clear tens. Go to CONVERT if wr_val<=99; else go directly to STORE with the ovf flag set.
  - CONVERT: each cycle, if rem>=10 then rem-=10 and tens+=1; else go to STORE.
  - STORE: write tens/rem and ovf into pair idx, return to IDLE.
- Latency from the acceptance edge to the digits becoming visible: tens+2 cycles (0 -> 2, 57 -> 7, 99 -> 11). Overflow (>=100) takes 1 cycle.
- wr_ready is low from the cycle after acceptance through STORE. wr_en while not ready is ignored, not queued.
- wr_idx >= NUM_PAIRS: the write is accepted and the result discarded; no stored state changes.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count, the scan index advances and wraps from 2*NUM_PAIRS-1 to 0.
  - dig_en and seg are both registered from the same scan index, so they change on the same edge and never glitch to a mismatched digit.
- Digit encoding:
  - ovf pair: both digits show dash 7'h40.
  - Tens digit with value 0 and blank_lz=1: blank.
  - Otherwise standard 0-9 patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - ACTIVE_LOW_SEG inverts the final seg only.
- Stored digits update in STORE while scanning continues. A digit being displayed may change mid-slot at that edge; this is acceptable.
- blank_lz is sampled combinationally into the seg register every cycle.
- rst_n low mid-conversion aborts: the partial result is discarded and all pairs are zeroed.

Decomposition:
- Shared package bcd_disp_pkg:
  - state enum (IDLE/CONVERT/STORE)
  - SEG_DIGIT[0:9], SEG_DASH=7'h40, SEG_BLANK=7'h00
  - digit/pair index width helper
- One natural sub-module: seg7_encoder (4-bit digit + blank + dash -> 7-bit pattern, combinational), instantiated once on the scan path.
- The converter FSM and the scan counter stay in the top module.

Test Plan (NUM_PAIRS=2, REFRESH_DIV=4, ACTIVE_LOW_SEG=0):
- Reset, then release -> dig_en=4'b0001, seg=7'h3F (digit 0), wr_ready=1; dig_en steps 0001->0010->0100->1000->0001, every 4 cycles.
- Write 57 to pair 0 -> wr_ready low 7 cycles; then seg=7'h07 in slot 0001 and seg=7'h6D in slot 0010.
- Write 5 to pair 1 with blank_lz=1 -> slot 0100 seg=7'h6D, slot 1000 seg=7'h00; blank_lz=0 -> slot 1000 seg=7'h3F.
- Write 120 to pair 1 -> 1-cycle busy; slots 0100 and 1000 show 7'h40. Then write 99 -> 11-cycle busy; both show 7'h6F.
- Assert wr_en with 33 while a conversion of 99 is busy -> ignored; pair retains 99.
- Drop rst_n during CONVERT of 88 -> next cycle all digits 0, dig_en=0, seg=0, wr_ready=1.
- Repeat with ACTIVE_LOW_SEG=1 -> every seg value is bitwise inverted.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the 2-digit 7-segment display scanner:
// converter states, segment patterns (bit order gfedcba) and an index-width helper.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    STORE
  } state_e;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational digit-to-segment encoder. Dash takes priority over blank;
// codes above 9 fall through to blank.
module seg7_encoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (!i_blank) begin
      for (int d = 0; d < 10; d++) begin
        if (i_digit == 4'(d)) o_seg = SEG_DIGIT[d];
      end
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Stores 0-99 values per display pair via a subtract-10 BCD converter and
// time-multiplexes all digits onto a shared segment bus with one-hot enables.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_PAIRS      = 2,
  parameter int REFRESH_DIV    = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [idx_width(NUM_PAIRS)-1:0]   wr_idx,
  input  logic [6:0]                        wr_val,
  output logic                              wr_ready,
  input  logic                              blank_lz,
  output logic [6:0]                        seg,
  output logic [2*NUM_PAIRS-1:0]            dig_en,
  output logic                              busy
);

  localparam int NUM_DIGITS = 2 * NUM_PAIRS;
  localparam int PAIR_W     = idx_width(NUM_PAIRS);
  localparam int DIG_W      = idx_width(NUM_DIGITS);
  localparam int REF_W      = idx_width(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : SEG_BLANK;

  state_e              r_state, w_state_next;
  logic [6:0]          r_rem, w_rem_next;
  logic [3:0]          r_tens_acc, w_tens_next;
  logic [PAIR_W-1:0]   r_idx, w_idx_next;
  logic                r_ovf_pend, w_ovf_next;
  logic                w_store;

  logic [3:0]          r_tens [NUM_PAIRS];
  logic [3:0]          r_ones [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] r_ovf;

  logic [REF_W-1:0]    r_refresh;
  logic [DIG_W-1:0]    r_scan_idx;
  logic [NUM_DIGITS-1:0] r_dig_en;
  logic [6:0]          r_seg;

  logic [PAIR_W-1:0]   w_scan_pair;
  logic                w_is_tens;
  logic [3:0]          w_cur_tens, w_cur_ones, w_digit;
  logic                w_cur_ovf, w_blank;
  logic [6:0]          w_enc, w_seg_next;

  assign wr_ready = (r_state == IDLE);
  assign busy     = ~wr_ready;
  assign seg      = r_seg;
  assign dig_en   = r_dig_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_tens_acc <= '0;
      r_idx      <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_tens_acc <= w_tens_next;
      r_idx      <= w_idx_next;
      r_ovf_pend <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_tens_next  = r_tens_acc;
    w_idx_next   = r_idx;
    w_ovf_next   = r_ovf_pend;
    w_store      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (wr_en) begin
          w_idx_next  = wr_idx;
          w_rem_next  = wr_val;
          w_tens_next = 4'd0;
          w_ovf_next  = (wr_val > 7'd99);
          w_state_next = (wr_val > 7'd99) ? STORE : CONVERT;
        end
      end
      CONVERT: begin
        if (r_rem >= 7'd10) begin
          w_rem_next  = r_rem - 7'd10;
          w_tens_next = r_tens_acc + 4'd1;
        end else begin
          w_state_next = STORE;
        end
      end
      STORE: begin
        w_store      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the digit store is a handful of flops read in parallel by the scan
  // mux, not a RAM, so it is safe and required to clear it on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PAIRS; k++) begin
        r_tens[k] <= '0;
        r_ones[k] <= '0;
      end
      r_ovf <= '0;
    end else if (w_store) begin
      // An out-of-range index matches no pair, so the result is dropped.
      for (int k = 0; k < NUM_PAIRS; k++) begin
        if (r_idx == PAIR_W'(k)) begin
          r_tens[k] <= r_tens_acc;
          r_ones[k] <= r_rem[3:0];
          r_ovf[k]  <= r_ovf_pend;
        end
      end
    end
  end

  assign w_scan_pair = PAIR_W'(r_scan_idx >> 1);
  assign w_is_tens   = r_scan_idx[0];

  always_comb begin
    w_cur_tens = '0;
    w_cur_ones = '0;
    w_cur_ovf  = 1'b0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (w_scan_pair == PAIR_W'(k)) begin
        w_cur_tens = r_tens[k];
        w_cur_ones = r_ones[k];
        w_cur_ovf  = r_ovf[k];
      end
    end
  end

  assign w_digit = w_is_tens ? w_cur_tens : w_cur_ones;
  assign w_blank = w_is_tens && blank_lz && (w_cur_tens == 4'd0);

  seg7_encoder u_enc (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .i_dash  (w_cur_ovf),
    .o_seg   (w_enc)
  );

  assign w_seg_next = ACTIVE_LOW_SEG ? ~w_enc : w_enc;

  // Enable and pattern both register from r_scan_idx so they switch together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh  <= '0;
      r_scan_idx <= '0;
      r_dig_en   <= '0;
      r_seg      <= SEG_OFF;
    end else begin
      if (r_refresh == REF_LAST) begin
        r_refresh  <= '0;
        r_scan_idx <= (r_scan_idx == DIG_LAST) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_dig_en <= NUM_DIGITS'(1) << r_scan_idx;
      r_seg    <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: an active-high and an active-low instance share all stimulus;
// every segment check expects the low-side instance to show the inverse.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [0:0] wr_idx;
  logic [6:0] wr_val;
  logic       blank_lz;
  logic       wr_ready, busy, wr_ready_n, busy_n;
  logic [6:0] seg, seg_n;
  logic [3:0] dig_en, dig_en_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.NUM_PAIRS(2), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .wr_ready(wr_ready), .blank_lz(blank_lz), .seg(seg), .dig_en(dig_en), .busy(busy)
  );

  bcd_display_scanner #(.NUM_PAIRS(2), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .wr_ready(wr_ready_n), .blank_lz(blank_lz), .seg(seg_n), .dig_en(dig_en_n), .busy(busy_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one write while idle; returns how many cycles busy stayed high.
  task automatic do_write(input logic idx, input logic [6:0] val, output int n_busy);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_val = val;
    tick();
    wr_en  = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 40) begin
      n_busy++;
      tick();
    end
    tick();
  endtask

  task automatic wait_slot(input logic [3:0] slot, output bit found,
                           output logic [6:0] s, output logic [6:0] sn);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dig_en === slot && dig_en_n === slot) found = 1'b1;
      else tick();
    end
    s  = seg;
    sn = seg_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_val = '0; blank_lz = 1'b0;
    tick(); tick();
    total++;
    if (dig_en !== 4'b0000 || seg !== 7'h00 || seg_n !== 7'h7F) begin
      bad++;
      $display("FAIL reset_outputs: dig_en=%b seg=%h seg_n=%h want 0000/00/7f", dig_en, seg, seg_n);
    end
    total++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || wr_ready_n !== 1'b1 || busy_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: wr_ready=%b busy=%b want 1/0", wr_ready, busy);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      total++;
      if (dig_en !== (4'b0001 << ((i / 4) % 4)) || seg !== 7'h3F || seg_n !== ~7'h3F) begin
        bad++;
        $display("FAIL scan_step_%0d: dig_en=%b seg=%h want %b/3f", i, dig_en, seg,
                 4'b0001 << ((i / 4) % 4));
      end
    end
  endtask

  task automatic test_write_57();
    int n; bit f; logic [6:0] s, sn;
    do_write(1'b0, 7'd57, n);
    total++;
    if (n != 7) begin bad++; $display("FAIL busy_57: cycles=%0d want 7", n); end
    wait_slot(4'b0001, f, s, sn);
    total++;
    if (!f || s !== 7'h07 || sn !== ~7'h07) begin
      bad++; $display("FAIL p0_ones_57: found=%0d seg=%h seg_n=%h want 07", f, s, sn);
    end
    wait_slot(4'b0010, f, s, sn);
    total++;
    if (!f || s !== 7'h6D || sn !== ~7'h6D) begin
      bad++; $display("FAIL p0_tens_57: found=%0d seg=%h seg_n=%h want 6d", f, s, sn);
    end
  endtask

  task automatic test_blank_lz();
    int n; bit f; logic [6:0] s, sn;
    blank_lz = 1'b1;
    do_write(1'b1, 7'd5, n);
    total++;
    if (n != 2) begin bad++; $display("FAIL busy_5: cycles=%0d want 2", n); end
    wait_slot(4'b0100, f, s, sn);
    total++;
    if (!f || s !== 7'h6D || sn !== ~7'h6D) begin
      bad++; $display("FAIL p1_ones_5: found=%0d seg=%h seg_n=%h want 6d", f, s, sn);
    end
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h00 || sn !== 7'h7F) begin
      bad++; $display("FAIL p1_tens_blank: found=%0d seg=%h seg_n=%h want 00", f, s, sn);
    end
    wait_slot(4'b0010, f, s, sn);
    total++;
    if (!f || s !== 7'h6D || sn !== ~7'h6D) begin
      bad++; $display("FAIL p0_tens_nonzero_lz: found=%0d seg=%h seg_n=%h want 6d", f, s, sn);
    end
    blank_lz = 1'b0;
    tick();
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h3F || sn !== ~7'h3F) begin
      bad++; $display("FAIL p1_tens_zero_shown: found=%0d seg=%h seg_n=%h want 3f", f, s, sn);
    end
  endtask

  task automatic test_overflow();
    int n; bit f; logic [6:0] s, sn;
    blank_lz = 1'b1;
    do_write(1'b1, 7'd120, n);
    total++;
    if (n != 1) begin bad++; $display("FAIL busy_120: cycles=%0d want 1", n); end
    wait_slot(4'b0100, f, s, sn);
    total++;
    if (!f || s !== 7'h40 || sn !== ~7'h40) begin
      bad++; $display("FAIL p1_ones_ovf: found=%0d seg=%h seg_n=%h want 40", f, s, sn);
    end
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h40 || sn !== ~7'h40) begin
      bad++; $display("FAIL p1_tens_ovf: found=%0d seg=%h seg_n=%h want 40", f, s, sn);
    end
    do_write(1'b0, 7'd100, n);
    total++;
    if (n != 1) begin bad++; $display("FAIL busy_100: cycles=%0d want 1", n); end
    wait_slot(4'b0001, f, s, sn);
    total++;
    if (!f || s !== 7'h40 || sn !== ~7'h40) begin
      bad++; $display("FAIL p0_ones_100: found=%0d seg=%h seg_n=%h want 40", f, s, sn);
    end
    do_write(1'b0, 7'd0, n);
    total++;
    if (n != 2) begin bad++; $display("FAIL busy_0: cycles=%0d want 2", n); end
    wait_slot(4'b0010, f, s, sn);
    total++;
    if (!f || s !== 7'h00 || sn !== 7'h7F) begin
      bad++; $display("FAIL p0_tens_0_blank: found=%0d seg=%h seg_n=%h want 00", f, s, sn);
    end
    do_write(1'b1, 7'd99, n);
    total++;
    if (n != 11) begin bad++; $display("FAIL busy_99: cycles=%0d want 11", n); end
    wait_slot(4'b0100, f, s, sn);
    total++;
    if (!f || s !== 7'h6F || sn !== ~7'h6F) begin
      bad++; $display("FAIL p1_ones_99: found=%0d seg=%h seg_n=%h want 6f", f, s, sn);
    end
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h6F || sn !== ~7'h6F) begin
      bad++; $display("FAIL p1_tens_99: found=%0d seg=%h seg_n=%h want 6f", f, s, sn);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_ignore_busy();
    int n; bit f; logic [6:0] s, sn;
    wr_en = 1'b1; wr_idx = 1'b1; wr_val = 7'd99;
    tick();
    wr_val = 7'd33;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL busy_hold_%0d: wr_ready=%b busy=%b want 0/1", i, wr_ready, busy);
      end
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    total++;
    if (n != 8) begin bad++; $display("FAIL busy_99_rest: cycles=%0d want 8", n); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL no_queue: busy=%b want 0", busy); end
    wait_slot(4'b0100, f, s, sn);
    total++;
    if (!f || s !== 7'h6F || sn !== ~7'h6F) begin
      bad++; $display("FAIL p1_ones_kept: found=%0d seg=%h seg_n=%h want 6f", f, s, sn);
    end
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h6F || sn !== ~7'h6F) begin
      bad++; $display("FAIL p1_tens_kept: found=%0d seg=%h seg_n=%h want 6f", f, s, sn);
    end
  endtask

  task automatic test_reset_abort();
    bit f; logic [6:0] s, sn;
    wr_en = 1'b1; wr_idx = 1'b0; wr_val = 7'd88;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_in_convert: busy=%b want 1", busy); end
    rst_n = 1'b0;
    tick();
    total++;
    if (dig_en !== 4'b0000 || seg !== 7'h00 || seg_n !== 7'h7F || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_reset: dig_en=%b seg=%h seg_n=%h wr_ready=%b want 0000/00/7f/1",
               dig_en, seg, seg_n, wr_ready);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: busy=%b want 0", busy); end
    wait_slot(4'b0001, f, s, sn);
    total++;
    if (!f || s !== 7'h3F || sn !== ~7'h3F) begin
      bad++; $display("FAIL abort_p0_ones: found=%0d seg=%h seg_n=%h want 3f", f, s, sn);
    end
    wait_slot(4'b1000, f, s, sn);
    total++;
    if (!f || s !== 7'h3F || sn !== ~7'h3F) begin
      bad++; $display("FAIL abort_p1_tens: found=%0d seg=%h seg_n=%h want 3f", f, s, sn);
    end
  endtask

  initial begin
    test_reset();
    test_write_57();
    test_blank_lz();
    test_overflow();
    test_ignore_busy();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
